// File: rtl/inst_fetch_responder_pkg.sv
// Shared types for the instruction fetch responder: FSM state encoding and the held bundle record.
package inst_fetch_responder_pkg;

    localparam int FETCH_ADDR_W   = 32;
    localparam int FETCH_BUNDLE_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2,
        VALID   = 2'd3
    } Fetch_State_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]   Inst_PC;
        logic [FETCH_BUNDLE_W-1:0] Inst_Data;
    } Fetch_Bundle;

endpackage

// File: rtl/fetch_timeout_wdt.sv
// Wait-cycle watchdog with a sticky timeout flag; generic enough to guard the data port as well.
module fetch_timeout_wdt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic done,
    output logic expire,
    output logic timeout
);

    localparam int CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

    logic [CNT_W-1:0] count_reg;
    logic             timeout_reg;

    // Fires on the LIMIT-th consecutive waiting cycle so the owner can abort at that edge.
    assign expire  = active && !done && (count_reg == CNT_W'(LIMIT - 1));
    assign timeout = timeout_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (start) begin
                count_reg <= '0;
            end else if (active && !done) begin
                count_reg <= count_reg + 1'b1;
            end
            if (expire) begin
                timeout_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/inst_fetch_responder.sv
// Responder side of the IF fetch handshake: one aligned two-instruction bundle request per fetch.
// Optional watchdog abort on unanswered requests is enabled with the FETCH_TIMEOUT_EN macro.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int ADDR_W      = FETCH_ADDR_W,
    parameter int BUNDLE_W    = FETCH_BUNDLE_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Inst_Req,
    input  logic [ADDR_W-1:0]   Fetch_PC,
    input  logic                Branch_Flush,
    output logic                Mem_Req,
    output logic [ADDR_W-1:0]   Mem_Addr,
    input  logic                Mem_Ack,
    input  logic [BUNDLE_W-1:0] Mem_Data,
    output logic                Inst_Ready,
    output logic [BUNDLE_W-1:0] Inst_Data,
    output logic [ADDR_W-1:0]   Inst_PC,
    output logic                Fetch_Busy,
    output logic                Fetch_Timeout
);

    Fetch_State_e        state_reg;
    logic                mem_req_reg;
    logic                inst_ready_reg;
    logic                fetch_busy_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [ADDR_W-1:0]   req_pc_reg;
    logic [ADDR_W-1:0]   inst_pc_reg;
    logic [BUNDLE_W-1:0] inst_data_reg;
    logic                wdt_expire;

`ifdef FETCH_TIMEOUT_EN
    logic wdt_start;

    // Counter restarts whenever a new wait period begins (fresh request or flush into DISCARD).
    assign wdt_start = ((state_reg == IDLE) && Inst_Req && !Branch_Flush) ||
                       ((state_reg == REQ) && !Mem_Ack && Branch_Flush);

    fetch_timeout_wdt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .start   (wdt_start),
        .active  (fetch_busy_reg),
        .done    (Mem_Ack),
        .expire  (wdt_expire),
        .timeout (Fetch_Timeout)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign wdt_expire         = 1'b0;
    assign Fetch_Timeout      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            mem_req_reg    <= 1'b0;
            inst_ready_reg <= 1'b0;
            fetch_busy_reg <= 1'b0;
            mem_addr_reg   <= '0;
            req_pc_reg     <= '0;
            inst_pc_reg    <= '0;
            inst_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Inst_Req && !Branch_Flush) begin
                        state_reg      <= REQ;
                        mem_req_reg    <= 1'b1;
                        fetch_busy_reg <= 1'b1;
                        mem_addr_reg   <= {Fetch_PC[ADDR_W-1:3], 3'b000};
                        req_pc_reg     <= Fetch_PC;
                    end
                end
                REQ: begin
                    if (Mem_Ack) begin
                        mem_req_reg    <= 1'b0;
                        fetch_busy_reg <= 1'b0;
                        if (Branch_Flush) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg      <= VALID;
                            inst_ready_reg <= 1'b1;
                            inst_data_reg  <= Mem_Data;
                            inst_pc_reg    <= req_pc_reg;
                        end
                    end else if (wdt_expire) begin
                        state_reg      <= IDLE;
                        mem_req_reg    <= 1'b0;
                        fetch_busy_reg <= 1'b0;
                    end else if (Branch_Flush) begin
                        // An un-acked request cannot be withdrawn; wait out the ack and drop it.
                        state_reg <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (Mem_Ack || wdt_expire) begin
                        state_reg      <= IDLE;
                        mem_req_reg    <= 1'b0;
                        fetch_busy_reg <= 1'b0;
                    end
                end
                VALID: begin
                    if (Branch_Flush || Inst_Req) begin
                        state_reg      <= IDLE;
                        inst_ready_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign Mem_Req    = mem_req_reg;
    assign Mem_Addr   = mem_addr_reg;
    assign Inst_Ready = inst_ready_reg;
    assign Inst_Data  = inst_data_reg;
    assign Inst_PC    = inst_pc_reg;
    assign Fetch_Busy = fetch_busy_reg;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder: vector table plus hand-written multi-cycle sequences.
module tb_inst_fetch_responder;
    import inst_fetch_responder_pkg::*;

    localparam int ADDR_W   = 32;
    localparam int BUNDLE_W = 64;
    localparam int TCYC     = 8;

    localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D2 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] D3 = 64'hDEAD_BEEF_0BAD_F00D;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                inst_req = 1'b0;
    logic [ADDR_W-1:0]   fetch_pc = '0;
    logic                branch_flush = 1'b0;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack = 1'b0;
    logic [BUNDLE_W-1:0] mem_data = '0;
    logic                inst_ready;
    logic [BUNDLE_W-1:0] inst_data;
    logic [ADDR_W-1:0]   inst_pc;
    logic                fetch_busy;
    logic                fetch_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_fetch_responder #(
        .ADDR_W      (ADDR_W),
        .BUNDLE_W    (BUNDLE_W),
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Inst_Req      (inst_req),
        .Fetch_PC      (fetch_pc),
        .Branch_Flush  (branch_flush),
        .Mem_Req       (mem_req),
        .Mem_Addr      (mem_addr),
        .Mem_Ack       (mem_ack),
        .Mem_Data      (mem_data),
        .Inst_Ready    (inst_ready),
        .Inst_Data     (inst_data),
        .Inst_PC       (inst_pc),
        .Fetch_Busy    (fetch_busy),
        .Fetch_Timeout (fetch_timeout)
    );

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        flush;
        logic        ack;
        logic [63:0] data;
        logic        e_mem_req;
        logic [31:0] e_addr;
        logic        e_ready;
        logic        e_busy;
        Fetch_Bundle e_bundle;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic req, input logic [31:0] pc, input logic flush,
                                input logic ack, input logic [63:0] data,
                                input logic e_mem_req, input logic [31:0] e_addr,
                                input logic e_ready, input logic e_busy,
                                input logic [31:0] e_pc, input logic [63:0] e_data);
        vec_t v;
        v.req                = req;
        v.pc                 = pc;
        v.flush              = flush;
        v.ack                = ack;
        v.data               = data;
        v.e_mem_req          = e_mem_req;
        v.e_addr             = e_addr;
        v.e_ready            = e_ready;
        v.e_busy             = e_busy;
        v.e_bundle.Inst_PC   = e_pc;
        v.e_bundle.Inst_Data = e_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] pc, input logic flush,
                         input logic ack, input logic [63:0] data);
        @(negedge clk);
        inst_req     = req;
        fetch_pc     = pc;
        branch_flush = flush;
        mem_ack      = ack;
        mem_data     = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        tick();
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 32'h0040_0004, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0040_0000, 1'b0, 1'b1, 32'h0, 64'h0);
        vecs[1]  = mk(1'b0, 32'h0,         1'b0, 1'b1, D1,    1'b0, 32'h0,         1'b1, 1'b0, 32'h0040_0004, D1);
        vecs[2]  = mk(1'b1, 32'h0040_0004, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 64'h0);
        vecs[3]  = mk(1'b1, 32'h0040_0008, 1'b0, 1'b1, D3,    1'b1, 32'h0040_0008, 1'b0, 1'b1, 32'h0, 64'h0);
        vecs[4]  = mk(1'b1, 32'h0040_000C, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0040_0008, 1'b0, 1'b1, 32'h0, 64'h0);
        vecs[5]  = mk(1'b0, 32'h0,         1'b1, 1'b1, D3,    1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 64'h0);
        vecs[6]  = mk(1'b1, 32'h0040_0010, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 64'h0);
        vecs[7]  = mk(1'b1, 32'h0000_100F, 1'b0, 1'b0, 64'h0, 1'b1, 32'h0000_1008, 1'b0, 1'b1, 32'h0, 64'h0);
        vecs[8]  = mk(1'b0, 32'h0,         1'b0, 1'b1, D2,    1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_100F, D2);
        vecs[9]  = mk(1'b0, 32'h0,         1'b0, 1'b1, D3,    1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_100F, D2);
        vecs[10] = mk(1'b1, 32'h0,         1'b1, 1'b0, 64'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 64'h0);
        vecs[11] = mk(1'b0, 32'h0,         1'b0, 1'b1, D3,    1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 64'h0);
        vecs[12] = mk(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 64'h0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'h0, 64'h0);
        vecs[13] = mk(1'b0, 32'h0,         1'b1, 1'b0, 64'h0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'h0, 64'h0);
        vecs[14] = mk(1'b1, 32'h0,         1'b1, 1'b0, 64'h0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'h0, 64'h0);
        vecs[15] = mk(1'b0, 32'h0,         1'b0, 1'b1, D1,    1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 64'h0);

        // Reset state while rst is held
        repeat (2) @(negedge clk);
        chk("reset_mem_req",    64'(mem_req),       64'(1'b0));
        chk("reset_mem_addr",   64'(mem_addr),      64'h0);
        chk("reset_ready",      64'(inst_ready),    64'(1'b0));
        chk("reset_data",       inst_data,          64'h0);
        chk("reset_pc",         64'(inst_pc),       64'h0);
        chk("reset_busy",       64'(fetch_busy),    64'(1'b0));
        chk("reset_timeout",    64'(fetch_timeout), 64'(1'b0));
        $display("txn reset: mem_req=%b ready=%b busy=%b", mem_req, inst_ready, fetch_busy);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].req, vecs[i].pc, vecs[i].flush, vecs[i].ack, vecs[i].data);
            tick();
            chk($sformatf("vec%0d_mem_req", i), 64'(mem_req),       64'(vecs[i].e_mem_req));
            chk($sformatf("vec%0d_busy", i),    64'(fetch_busy),    64'(vecs[i].e_busy));
            chk($sformatf("vec%0d_ready", i),   64'(inst_ready),    64'(vecs[i].e_ready));
            chk($sformatf("vec%0d_timeout", i), 64'(fetch_timeout), 64'(1'b0));
            if (vecs[i].e_mem_req)
                chk($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(vecs[i].e_addr));
            if (vecs[i].e_ready) begin
                chk($sformatf("vec%0d_pc", i),   64'(inst_pc), 64'(vecs[i].e_bundle.Inst_PC));
                chk($sformatf("vec%0d_data", i), inst_data,    vecs[i].e_bundle.Inst_Data);
            end
            $display("txn vec%0d: req=%b pc=%h flush=%b ack=%b -> mem_req=%b addr=%h ready=%b busy=%b pc_out=%h",
                     i, vecs[i].req, vecs[i].pc, vecs[i].flush, vecs[i].ack,
                     mem_req, mem_addr, inst_ready, fetch_busy, inst_pc);
        end

        // Stall in VALID for 10 cycles, then consume
        drive(1'b1, 32'h0040_0024, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, D2);
        tick();
        chk("stall_enter_ready", 64'(inst_ready), 64'(1'b1));
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 32'h0040_0100, 1'b0, 1'b0, D3);
            tick();
            chk($sformatf("stall%0d_ready", k),   64'(inst_ready), 64'(1'b1));
            chk($sformatf("stall%0d_data", k),    inst_data,       D2);
            chk($sformatf("stall%0d_pc", k),      64'(inst_pc),    64'h0040_0024);
            chk($sformatf("stall%0d_mem_req", k), 64'(mem_req),    64'(1'b0));
        end
        $display("txn stall: held data=%h pc=%h for 10 cycles", inst_data, inst_pc);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 64'h0);
        tick();
        chk("consume_ready",   64'(inst_ready), 64'(1'b0));
        chk("consume_mem_req", 64'(mem_req),    64'(1'b0));
        chk("consume_busy",    64'(fetch_busy), 64'(1'b0));
        $display("txn consume: ready=%b mem_req=%b", inst_ready, mem_req);

        // Flush in REQ, ack four cycles later
        drive(1'b1, 32'h0040_0030, 1'b0, 1'b0, 64'h0);
        tick();
        chk("disc_req_mem_req", 64'(mem_req), 64'(1'b1));
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        tick();
        chk("disc_enter_mem_req", 64'(mem_req),    64'(1'b1));
        chk("disc_enter_busy",    64'(fetch_busy), 64'(1'b1));
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h0040_0040, 1'b0, 1'b0, 64'h0);
            tick();
            chk($sformatf("disc%0d_mem_req", k), 64'(mem_req),    64'(1'b1));
            chk($sformatf("disc%0d_ready", k),   64'(inst_ready), 64'(1'b0));
            chk($sformatf("disc%0d_addr", k),    64'(mem_addr),   64'h0040_0030);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, D1);
        tick();
        chk("disc_done_mem_req", 64'(mem_req),    64'(1'b0));
        chk("disc_done_busy",    64'(fetch_busy), 64'(1'b0));
        chk("disc_done_ready",   64'(inst_ready), 64'(1'b0));
        idle_cycle();
        chk("disc_after_ready", 64'(inst_ready), 64'(1'b0));
        $display("txn discard: mem_req=%b busy=%b ready=%b", mem_req, fetch_busy, inst_ready);

        // Asynchronous reset mid-REQ, checked before the next clock edge
        drive(1'b1, 32'h0040_0050, 1'b0, 1'b0, 64'h0);
        tick();
        chk("areq_pre_mem_req", 64'(mem_req), 64'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("areq_mem_req", 64'(mem_req),    64'(1'b0));
        chk("areq_busy",    64'(fetch_busy), 64'(1'b0));
        chk("areq_ready",   64'(inst_ready), 64'(1'b0));
        $display("txn async_rst_req: mem_req=%b busy=%b ready=%b", mem_req, fetch_busy, inst_ready);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        rst = 1'b0;

        // Asynchronous reset in VALID
        drive(1'b1, 32'h0040_0060, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, D3);
        tick();
        chk("aval_pre_ready", 64'(inst_ready), 64'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("aval_ready", 64'(inst_ready), 64'(1'b0));
        $display("txn async_rst_valid: ready=%b", inst_ready);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        rst = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        // Watchdog: no ack for TCYC waiting cycles
        drive(1'b1, 32'h0040_0070, 1'b0, 1'b0, 64'h0);
        tick();
        chk("wdt_start_mem_req", 64'(mem_req), 64'(1'b1));
        for (int k = 1; k < TCYC; k++) begin
            idle_cycle();
            chk($sformatf("wdt_wait%0d_timeout", k), 64'(fetch_timeout), 64'(1'b0));
            chk($sformatf("wdt_wait%0d_mem_req", k), 64'(mem_req),       64'(1'b1));
        end
        idle_cycle();
        chk("wdt_fire_timeout", 64'(fetch_timeout), 64'(1'b1));
        chk("wdt_fire_mem_req", 64'(mem_req),       64'(1'b0));
        chk("wdt_fire_busy",    64'(fetch_busy),    64'(1'b0));
        $display("txn watchdog: timeout=%b mem_req=%b", fetch_timeout, mem_req);
        drive(1'b1, 32'h0040_0080, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, D1);
        tick();
        chk("wdt_sticky_ready",   64'(inst_ready),    64'(1'b1));
        chk("wdt_sticky_timeout", 64'(fetch_timeout), 64'(1'b1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("wdt_rst_timeout", 64'(fetch_timeout), 64'(1'b0));
        $display("txn watchdog_rst: timeout=%b", fetch_timeout);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        rst = 1'b0;
`endif

        idle_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
